pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the generalised successor to the fixed D/E control latch. It carries an arbitrary-width control bundle and data bundle plus PC, branch-delay flag, exception code and a valid bit. It supports hold (freeze), stall-bubble, exception flush and a saturating bubble counter. One instance is used per stage boundary (F/D, D/E, E/M, M/W), with mode selected by parameter.

Parameters:
CTRL_W, 16, width of control bundle (RegWrite, MemtoReg, MemWrite, ALUcontrol, ALUsrc, RegDst, ...)
DATA_W, 96, width of data bundle (operands, immediate, dest reg, ...)
BUBBLE_ON_STALL, 1, 1: stall inserts a bubble (D/E style); 0: stall holds contents (F/D style)
FLUSH_PC, 32'h0000_4180, PC value loaded on flush
CNT_W, 16, width of bubble counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
stall  input  1  hazard stall from the hazard unit
hold  input  1  freeze this stage (downstream busy, e.g. mult/div)
flush  input  1  exception/eret flush
cnt_clr  input  1  synchronous clear of bubble_cnt
ctrl_d  input  CTRL_W  control bundle in
data_d  input  DATA_W  data bundle in
pc_d  input  32  PC in
bd_d  input  1  branch-delay-slot flag in
exc_d  input  5  exception code in (0 = none)
valid_d  input  1  instruction valid in
ctrl_q  output  CTRL_W  registered control
data_q  output  DATA_W  registered data
pc_q  output  32  registered PC
bd_q  output  1  registered BD flag
exc_q  output  5  registered exception code
valid_q  output  1  registered valid
bubble_cnt  output  CNT_W  saturating count of stall bubbles

Behaviour:
- All outputs are registered and update only on posedge clk. Latency is 1 cycle from d to q on advance.
- Per-cycle priority, first match wins: reset > flush > hold > stall > advance.
- reset: ctrl_q=0, data_q=0, pc_q=0, bd_q=0, exc_q=0, valid_q=0, bubble_cnt=0.
- flush: ctrl_q=0, data_q=0, exc_q=0, valid_q=0, bd_q=0, pc_q=FLUSH_PC. bubble_cnt is unchanged.
- hold: all q registers keep their values. bubble_cnt is unchanged. hold overrides stall.
- stall with BUBBLE_ON_STALL=1:
  - ctrl_q=0, data_q=0, exc_q=0, valid_q=0.
  - pc_q<=pc_d and bd_q<=bd_d, so that a bubble reaching CP0 reports the correct EPC/BD.
  - bubble_cnt increments.
- stall with BUBBLE_ON_STALL=0: behaves exactly as hold. bubble_cnt is unchanged.
- advance (none of the above asserted): every q <= its d.
- bubble_cnt:
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr clears it to 0 the next cycle.
  - If cnt_clr and a counting stall occur in the same cycle, the result is 0 (clear wins).
  - reset also clears it.
- A bubble is defined as valid_q=0 with ctrl_q all-zero. Downstream logic must treat ctrl_q=0 as a no-op, with no reg or mem write.
- No combinational path from any input to any output.
- Reset mid-operation (during hold or stall) takes effect on the next edge regardless of the other inputs.

Test Plan:
- Reset then advance: assert reset 1 cycle, then drive ctrl_d=16'h00A5, data_d=96'h1, pc_d=32'h3000, valid_d=1 -> after reset all q=0 and bubble_cnt=0; one edge later ctrl_q=16'h00A5, pc_q=32'h3000, valid_q=1.
- Stall bubble (BUBBLE_ON_STALL=1): stall=1 for 3 cycles with pc_d=32'h3008 and bd_d=1 -> ctrl_q=0, valid_q=0, pc_q=32'h3008, bd_q=1, bubble_cnt=3.
- Hold vs stall: hold=1 and stall=1 together for 2 cycles after loading ctrl_q=16'h00A5 -> ctrl_q stays 16'h00A5 and bubble_cnt is unchanged. The BUBBLE_ON_STALL=0 instance with stall alone also holds.
- Flush priority: flush=1, hold=1, stall=1 with exc_d=5'd4 -> ctrl_q=0, exc_q=0, valid_q=0, bd_q=0, pc_q=32'h4180.
- Counter saturation and clear: CNT_W=2 with 5 stall cycles -> bubble_cnt=3 and stays 3. cnt_clr together with stall -> 0.
- Mid-stall reset: during a stall sequence with bubble_cnt=2, assert reset -> next edge all outputs 0 and bubble_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: carries control/data bundles, PC, BD flag,
// exception code and valid, with hold, stall-bubble, flush and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int          CTRL_W          = 16,
    parameter int          DATA_W          = 96,
    parameter bit          BUBBLE_ON_STALL = 1'b1,
    parameter logic [31:0] FLUSH_PC        = 32'h0000_4180,
    parameter int          CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              hold,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    input  logic [31:0]       pc_d,
    input  logic              bd_d,
    input  logic [4:0]        exc_d,
    input  logic              valid_d,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q,
    output logic [31:0]       pc_q,
    output logic              bd_q,
    output logic [4:0]        exc_q,
    output logic              valid_q,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic freeze;
    logic bubble;

    // In hold-style stages a stall is indistinguishable from a freeze.
    assign freeze = hold || (stall && !BUBBLE_ON_STALL);
    assign bubble = !flush && !hold && stall && BUBBLE_ON_STALL;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            pc_q    <= '0;
            bd_q    <= 1'b0;
            exc_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            pc_q    <= FLUSH_PC;
            bd_q    <= 1'b0;
            exc_q   <= '0;
            valid_q <= 1'b0;
        end else if (freeze) begin
            ctrl_q  <= ctrl_q;
            data_q  <= data_q;
            pc_q    <= pc_q;
            bd_q    <= bd_q;
            exc_q   <= exc_q;
            valid_q <= valid_q;
        end else if (stall) begin
            // Bubble keeps PC/BD moving so CP0 still reports a correct EPC for it.
            ctrl_q  <= '0;
            data_q  <= '0;
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            exc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            bubble_cnt <= '0;
        end else if (bubble && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: bubble instance, hold-style instance and a 2-bit counter instance.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, stall, hold, flush, cnt_clr;
    logic [15:0] ctrl_d;
    logic [95:0] data_d;
    logic [31:0] pc_d;
    logic        bd_d;
    logic [4:0]  exc_d;
    logic        valid_d;

    logic [15:0] a_ctrl, b_ctrl, c_ctrl;
    logic [95:0] a_data, b_data, c_data;
    logic [31:0] a_pc, b_pc, c_pc;
    logic        a_bd, b_bd, c_bd;
    logic [4:0]  a_exc, b_exc, c_exc;
    logic        a_valid, b_valid, c_valid;
    logic [15:0] a_cnt, b_cnt;
    logic [1:0]  c_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_a (
        .clk(clk), .reset(reset), .stall(stall), .hold(hold), .flush(flush), .cnt_clr(cnt_clr),
        .ctrl_d(ctrl_d), .data_d(data_d), .pc_d(pc_d), .bd_d(bd_d), .exc_d(exc_d), .valid_d(valid_d),
        .ctrl_q(a_ctrl), .data_q(a_data), .pc_q(a_pc), .bd_q(a_bd), .exc_q(a_exc), .valid_q(a_valid),
        .bubble_cnt(a_cnt)
    );

    pipe_stage_reg #(.BUBBLE_ON_STALL(1'b0)) u_b (
        .clk(clk), .reset(reset), .stall(stall), .hold(hold), .flush(flush), .cnt_clr(cnt_clr),
        .ctrl_d(ctrl_d), .data_d(data_d), .pc_d(pc_d), .bd_d(bd_d), .exc_d(exc_d), .valid_d(valid_d),
        .ctrl_q(b_ctrl), .data_q(b_data), .pc_q(b_pc), .bd_q(b_bd), .exc_q(b_exc), .valid_q(b_valid),
        .bubble_cnt(b_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .stall(stall), .hold(hold), .flush(flush), .cnt_clr(cnt_clr),
        .ctrl_d(ctrl_d), .data_d(data_d), .pc_d(pc_d), .bd_d(bd_d), .exc_d(exc_d), .valid_d(valid_d),
        .ctrl_q(c_ctrl), .data_q(c_data), .pc_q(c_pc), .bd_q(c_bd), .exc_q(c_exc), .valid_q(c_valid),
        .bubble_cnt(c_cnt)
    );

    task automatic apply_stimulus(input int edges);
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; hold = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        ctrl_d = '0; data_d = '0; pc_d = '0; bd_d = 1'b0; exc_d = '0; valid_d = 1'b0;
        apply_stimulus(1);
        check_output("rst_a_ctrl", a_ctrl, 0);
        check_output("rst_a_data", a_data, 0);
        check_output("rst_a_pc", a_pc, 0);
        check_output("rst_a_valid", a_valid, 0);
        check_output("rst_a_cnt", a_cnt, 0);
        check_output("rst_c_cnt", c_cnt, 0);

        // advance
        reset = 1'b0;
        ctrl_d = 16'h00A5; data_d = 96'h1; pc_d = 32'h3000; valid_d = 1'b1; exc_d = 5'd3;
        apply_stimulus(1);
        check_output("adv_a_ctrl", a_ctrl, 16'h00A5);
        check_output("adv_a_data", a_data, 96'h1);
        check_output("adv_a_pc", a_pc, 32'h3000);
        check_output("adv_a_valid", a_valid, 1);
        check_output("adv_a_exc", a_exc, 3);
        check_output("adv_b_ctrl", b_ctrl, 16'h00A5);

        // three stall cycles
        stall = 1'b1; pc_d = 32'h3008; bd_d = 1'b1;
        apply_stimulus(3);
        check_output("stall_a_ctrl", a_ctrl, 0);
        check_output("stall_a_data", a_data, 0);
        check_output("stall_a_valid", a_valid, 0);
        check_output("stall_a_exc", a_exc, 0);
        check_output("stall_a_pc", a_pc, 32'h3008);
        check_output("stall_a_bd", a_bd, 1);
        check_output("stall_a_cnt", a_cnt, 3);
        check_output("stall_b_ctrl", b_ctrl, 16'h00A5);
        check_output("stall_b_pc", b_pc, 32'h3000);
        check_output("stall_b_valid", b_valid, 1);
        check_output("stall_b_cnt", b_cnt, 0);
        check_output("stall_c_cnt", c_cnt, 3);

        // reload then hold together with stall
        stall = 1'b0; pc_d = 32'h300C; bd_d = 1'b0;
        apply_stimulus(1);
        check_output("reload_a_ctrl", a_ctrl, 16'h00A5);
        check_output("reload_a_cnt", a_cnt, 3);
        hold = 1'b1; stall = 1'b1; ctrl_d = 16'h0011; pc_d = 32'h3010;
        apply_stimulus(2);
        check_output("hold_a_ctrl", a_ctrl, 16'h00A5);
        check_output("hold_a_pc", a_pc, 32'h300C);
        check_output("hold_a_cnt", a_cnt, 3);
        check_output("hold_c_cnt", c_cnt, 3);

        // two more stalls: 2-bit counter saturates, wide counter keeps going
        hold = 1'b0;
        apply_stimulus(2);
        check_output("sat_c_cnt", c_cnt, 3);
        check_output("sat_a_cnt", a_cnt, 5);
        check_output("sat_a_pc", a_pc, 32'h3010);
        check_output("sat_b_ctrl", b_ctrl, 16'h00A5);

        // clear wins over counting stall
        cnt_clr = 1'b1;
        apply_stimulus(1);
        check_output("clr_a_cnt", a_cnt, 0);
        check_output("clr_c_cnt", c_cnt, 0);

        // flush beats hold and stall
        cnt_clr = 1'b0; flush = 1'b1; hold = 1'b1; stall = 1'b1;
        exc_d = 5'd4; bd_d = 1'b1; valid_d = 1'b1;
        apply_stimulus(1);
        check_output("flush_a_ctrl", a_ctrl, 0);
        check_output("flush_a_exc", a_exc, 0);
        check_output("flush_a_valid", a_valid, 0);
        check_output("flush_a_bd", a_bd, 0);
        check_output("flush_a_pc", a_pc, 32'h4180);
        check_output("flush_a_cnt", a_cnt, 0);
        check_output("flush_b_pc", b_pc, 32'h4180);

        // reset in the middle of a stall run
        flush = 1'b0; hold = 1'b0; stall = 1'b1; pc_d = 32'h3020;
        apply_stimulus(2);
        check_output("mid_a_cnt", a_cnt, 2);
        reset = 1'b1;
        apply_stimulus(1);
        check_output("mrst_a_cnt", a_cnt, 0);
        check_output("mrst_a_pc", a_pc, 0);
        check_output("mrst_a_bd", a_bd, 0);
        check_output("mrst_c_cnt", c_cnt, 0);
        check_output("mrst_b_ctrl", b_ctrl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
